// File: rtl/wb_demux_scoreboard.sv
// Write-back demultiplexer and register-pending scoreboard.
// One write-back per cycle becomes a registered one-hot write enable plus
// write data for the register file. A per-register pending bit is set when
// an instruction issues and cleared when its write-back arrives, so the
// issue stage can stall on RAW and WAW hazards.
module wb_demux_scoreboard #(
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int DW       = 64,
  parameter int ZERO_REG = 31
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_addr,
  output logic            iss_ready,
  input  logic [AW-1:0]   src_a,
  input  logic [AW-1:0]   src_b,
  output logic            hazard_a,
  output logic            hazard_b,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_addr,
  input  logic [DW-1:0]   wb_data,
  output logic [NREG-1:0] reg_we,
  output logic [DW-1:0]   reg_wdata,
  output logic [NREG-1:0] pending,
  output logic [AW:0]     out_cnt,
  output logic            err_spurious
);

  localparam logic [AW-1:0] ZADDR = AW'(ZERO_REG);

  logic [NREG-1:0] pending_q, pending_d;
  logic [NREG-1:0] reg_we_q, reg_we_d;
  logic [DW-1:0]   reg_wdata_q, reg_wdata_d;
  logic [AW:0]     out_cnt_q, out_cnt_d;
  logic            err_q, err_d;

  logic clr;
  logic set;
  logic cnt_inc;
  logic cnt_dec;

  // A write-back that retires this cycle releases a WAW stall on the same
  // register immediately; the zero register never stalls.
  assign iss_ready = iss_valid &&
                     (iss_addr == ZADDR || !pending_q[iss_addr] ||
                      (wb_valid && wb_addr == iss_addr));

  // No bypass: a same-cycle write-back only removes the hazard flag.
  assign hazard_a = (src_a != ZADDR) && pending_q[src_a] &&
                    !(wb_valid && wb_addr == src_a);
  assign hazard_b = (src_b != ZADDR) && pending_q[src_b] &&
                    !(wb_valid && wb_addr == src_b);

  // Write-backs and reservations to the zero register are ignored entirely.
  assign clr = wb_valid && (wb_addr != ZADDR);
  assign set = iss_ready && (iss_addr != ZADDR);

  // Next-state for scoreboard, counter, error flag and demux outputs.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update, so no latch can be inferred.
    pending_d   = pending_q;
    reg_we_d    = '0;
    reg_wdata_d = reg_wdata_q;
    cnt_inc     = 1'b0;
    cnt_dec     = 1'b0;
    err_d       = err_q;

    if (clr) begin
      pending_d[wb_addr] = 1'b0;
      reg_we_d           = NREG'(1) << wb_addr;
      reg_wdata_d        = wb_data;
      cnt_dec            = pending_q[wb_addr] && !(set && iss_addr == wb_addr);
      if (!pending_q[wb_addr]) begin
        err_d = 1'b1;
      end
    end

    // Applied after the clear so a same-address reservation wins.
    if (set) begin
      pending_d[iss_addr] = 1'b1;
      cnt_inc             = !pending_q[iss_addr];
    end

    out_cnt_d = out_cnt_q + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
  end

  // State registers; asynchronous reset drops all outstanding reservations.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q   <= '0;
      reg_we_q    <= '0;
      reg_wdata_q <= '0;
      out_cnt_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of statement order.
      pending_q   <= pending_d;
      reg_we_q    <= reg_we_d;
      reg_wdata_q <= reg_wdata_d;
      out_cnt_q   <= out_cnt_d;
      err_q       <= err_d;
    end
  end

  assign pending      = pending_q;
  assign reg_we       = reg_we_q;
  assign reg_wdata    = reg_wdata_q;
  assign out_cnt      = out_cnt_q;
  assign err_spurious = err_q;

endmodule

// File: tb/tb_wb_demux_scoreboard.sv
// Self-checking bench for wb_demux_scoreboard: a directed vector table,
// hand-written multi-cycle sequences and a randomized run against a
// set-based reference model of the scoreboard.
module tb_wb_demux_scoreboard;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 64;
  localparam int ZR   = 31;
  localparam int NRAND = 2000;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            iss_valid = 1'b0;
  logic [AW-1:0]   iss_addr = '0;
  logic            iss_ready;
  logic [AW-1:0]   src_a = '0;
  logic [AW-1:0]   src_b = '0;
  logic            hazard_a;
  logic            hazard_b;
  logic            wb_valid = 1'b0;
  logic [AW-1:0]   wb_addr = '0;
  logic [DW-1:0]   wb_data = '0;
  logic [NREG-1:0] reg_we;
  logic [DW-1:0]   reg_wdata;
  logic [NREG-1:0] pending;
  logic [AW:0]     out_cnt;
  logic            err_spurious;

  int total = 0;
  int bad   = 0;

  wb_demux_scoreboard #(.NREG(NREG), .AW(AW), .DW(DW), .ZERO_REG(ZR)) dut (
    .clk(clk), .reset_n(reset_n),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
    .src_a(src_a), .src_b(src_b), .hazard_a(hazard_a), .hazard_b(hazard_b),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .reg_we(reg_we), .reg_wdata(reg_wdata), .pending(pending),
    .out_cnt(out_cnt), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          iv;
    logic [AW-1:0] ia;
    logic [AW-1:0] sa;
    logic [AW-1:0] sb;
    logic          wv;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          e_rdy;
    logic          e_ha;
    logic          e_hb;
    logic [31:0]   e_pend;
    logic [5:0]    e_cnt;
    logic [31:0]   e_we;
    logic [63:0]   e_wd;
    logic          e_err;
  } vec_t;

  function automatic vec_t mk(input logic iv, input int ia, input int sa, input int sb,
                              input logic wv, input int wa, input logic [63:0] wd,
                              input logic rdy, input logic ha, input logic hb,
                              input logic [31:0] pend, input int cnt,
                              input logic [31:0] we, input logic [63:0] ewd,
                              input logic err);
    vec_t v;
    v.iv = iv; v.ia = AW'(ia); v.sa = AW'(sa); v.sb = AW'(sb);
    v.wv = wv; v.wa = AW'(wa); v.wd = wd;
    v.e_rdy = rdy; v.e_ha = ha; v.e_hb = hb;
    v.e_pend = pend; v.e_cnt = 6'(cnt); v.e_we = we; v.e_wd = ewd; v.e_err = err;
    return v;
  endfunction

  task automatic drive(input logic iv, input logic [AW-1:0] ia, input logic [AW-1:0] sa,
                       input logic [AW-1:0] sb, input logic wv, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd);
    iss_valid = iv; iss_addr = ia; src_a = sa; src_b = sb;
    wb_valid = wv; wb_addr = wa; wb_data = wd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, '0, '0);
    @(negedge clk);
    check("rst_we", 64'(reg_we), 64'h0);
    check("rst_wdata", reg_wdata, 64'h0);
    check("rst_pending", 64'(pending), 64'h0);
    check("rst_cnt", 64'(out_cnt), 64'h0);
    check("rst_err", 64'(err_spurious), 64'h0);
    reset_n = 1'b1;
  endtask

  // Reference model: set of pending registers plus last write-back outputs.
  bit          m_pend[NREG];
  logic [31:0] m_we;
  logic [63:0] m_wd;
  bit          m_err;

  function automatic logic [31:0] model_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < NREG; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic int model_cnt();
    int c = 0;
    for (int i = 0; i < NREG; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  vec_t vecs[10];

  initial begin
    // Directed sequence from reset: reserve, hazard, retire, WAW stall/release,
    // zero-register traffic, spurious write-back.
    vecs[0] = mk(1, 3, 3, 0, 0, 0, 64'h0,  1, 0, 0, 32'h08, 1, 32'h0,  64'h0, 0);
    vecs[1] = mk(0, 0, 3, 0, 0, 0, 64'h0,  0, 1, 0, 32'h08, 1, 32'h0,  64'h0, 0);
    vecs[2] = mk(0, 0, 3, 0, 1, 3, 64'hDEADBEEF_00000001,
                                          0, 0, 0, 32'h00, 0, 32'h08, 64'hDEADBEEF_00000001, 0);
    vecs[3] = mk(0, 0, 3, 0, 0, 0, 64'h0,  0, 0, 0, 32'h00, 0, 32'h0,  64'hDEADBEEF_00000001, 0);
    vecs[4] = mk(1, 5, 0, 5, 0, 0, 64'h0,  1, 0, 0, 32'h20, 1, 32'h0,  64'hDEADBEEF_00000001, 0);
    vecs[5] = mk(1, 5, 0, 5, 0, 0, 64'h0,  0, 0, 1, 32'h20, 1, 32'h0,  64'hDEADBEEF_00000001, 0);
    vecs[6] = mk(1, 5, 0, 5, 1, 5, 64'h55, 1, 0, 0, 32'h20, 1, 32'h20, 64'h55, 0);
    vecs[7] = mk(1, 31, 31, 5, 1, 31, 64'hFFFF_FFFF_FFFF_FFFF,
                                          1, 0, 1, 32'h20, 1, 32'h0,  64'h55, 0);
    vecs[8] = mk(0, 0, 7, 5, 1, 7, 64'h77, 0, 0, 1, 32'h20, 1, 32'h80, 64'h77, 1);
    vecs[9] = mk(0, 0, 0, 5, 0, 0, 64'h0,  0, 0, 1, 32'h20, 1, 32'h0,  64'h77, 1);

    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vecs[i].iv, vecs[i].ia, vecs[i].sa, vecs[i].sb, vecs[i].wv, vecs[i].wa, vecs[i].wd);
      #1;
      check($sformatf("v%0d_ready", i), 64'(iss_ready), 64'(vecs[i].e_rdy));
      check($sformatf("v%0d_haz_a", i), 64'(hazard_a), 64'(vecs[i].e_ha));
      check($sformatf("v%0d_haz_b", i), 64'(hazard_b), 64'(vecs[i].e_hb));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_pending", i), 64'(pending), 64'(vecs[i].e_pend));
      check($sformatf("v%0d_cnt", i), 64'(out_cnt), 64'(vecs[i].e_cnt));
      check($sformatf("v%0d_we", i), 64'(reg_we), 64'(vecs[i].e_we));
      check($sformatf("v%0d_wdata", i), reg_wdata, vecs[i].e_wd);
      check($sformatf("v%0d_err", i), 64'(err_spurious), 64'(vecs[i].e_err));
    end

    // Fill the scoreboard with registers 0..30 back to back.
    do_reset();
    for (int r = 0; r < 31; r++) begin
      @(negedge clk);
      drive(1'b1, AW'(r), '0, '0, 1'b0, '0, '0);
      #1;
      check($sformatf("fill%0d_ready", r), 64'(iss_ready), 64'h1);
    end
    @(posedge clk);
    #1;
    check("fill_cnt", 64'(out_cnt), 64'd31);
    check("fill_pending", 64'(pending), 64'h7FFF_FFFF);
    // Same-address retire and re-reserve while full: count must not move.
    @(negedge clk);
    drive(1'b1, AW'(4), '0, '0, 1'b1, AW'(4), 64'h1234_5678_9ABC_DEF0);
    #1;
    check("full_waw_ready", 64'(iss_ready), 64'h1);
    @(posedge clk);
    #1;
    check("full_waw_cnt", 64'(out_cnt), 64'd31);
    check("full_waw_pending", 64'(pending), 64'h7FFF_FFFF);
    check("full_waw_we", 64'(reg_we), 64'h10);
    // Asynchronous reset in the middle of the clock period.
    #1;
    reset_n = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, '0, '0);
    #1;
    check("async_we", 64'(reg_we), 64'h0);
    check("async_wdata", reg_wdata, 64'h0);
    check("async_pending", 64'(pending), 64'h0);
    check("async_cnt", 64'(out_cnt), 64'h0);
    check("async_err", 64'(err_spurious), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Randomized run against the reference model.
    for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
    m_we = '0; m_wd = '0; m_err = 1'b0;
    for (int n = 0; n < NRAND; n++) begin
      logic          iv, wv;
      logic [AW-1:0] ia, wa, sa, sb;
      logic [DW-1:0] wd;
      logic          e_rdy, e_ha, e_hb;
      int            pend_list[$];
      @(negedge clk);
      for (int i = 0; i < NREG; i++) if (m_pend[i]) pend_list.push_back(i);
      iv = ($urandom_range(0, 99) < 60);
      ia = AW'($urandom_range(0, NREG - 1));
      wv = ($urandom_range(0, 99) < 50);
      if (pend_list.size() > 0 && $urandom_range(0, 99) < 90)
        wa = AW'(pend_list[$urandom_range(0, pend_list.size() - 1)]);
      else
        wa = AW'($urandom_range(0, NREG - 1));
      if ($urandom_range(0, 3) == 0) ia = wa;
      sa = AW'($urandom_range(0, NREG - 1));
      sb = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, NREG - 1));
      wd = {$urandom, $urandom};
      drive(iv, ia, sa, sb, wv, wa, wd);

      e_rdy = iv && (ia == AW'(ZR) || !m_pend[ia] || (wv && wa == ia));
      e_ha  = (sa != AW'(ZR)) && m_pend[sa] && !(wv && wa == sa);
      e_hb  = (sb != AW'(ZR)) && m_pend[sb] && !(wv && wa == sb);
      #1;
      check("rnd_ready", 64'(iss_ready), 64'(e_rdy));
      check("rnd_haz_a", 64'(hazard_a), 64'(e_ha));
      check("rnd_haz_b", 64'(hazard_b), 64'(e_hb));

      if (wv && wa != AW'(ZR)) begin
        if (!m_pend[wa]) m_err = 1'b1;
        m_pend[wa] = 1'b0;
        m_we = 32'h1 << wa;
        m_wd = wd;
      end else begin
        m_we = '0;
      end
      if (e_rdy && ia != AW'(ZR)) m_pend[ia] = 1'b1;

      @(posedge clk);
      #1;
      check("rnd_pending", 64'(pending), 64'(model_vec()));
      check("rnd_cnt", 64'(out_cnt), 64'(model_cnt()));
      check("rnd_we", 64'(reg_we), 64'(m_we));
      check("rnd_wdata", reg_wdata, m_wd);
      check("rnd_err", 64'(err_spurious), 64'(m_err));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
